// File: rtl/beat_sequencer.sv
// Tempo-divided beat counter that addresses a combinational song ROM and registers the returned notes.
// Optional articulation gaps between beats are enabled by defining BEAT_SEQ_ARTIC_EN.
module beat_sequencer #(
    parameter int NOTE_W = 4,
    parameter int BEAT_W = 7,
    parameter int DIV_W  = 27,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [BEAT_W-1:0] song_len,
    input  logic [DIV_W-1:0]  tempo_div,
    input  logic [NOTE_W-1:0] rom_left_note,
    input  logic [NOTE_W-1:0] rom_right_note,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic [NOTE_W-1:0] left_note,
    output logic [NOTE_W-1:0] right_note,
    output logic              beat_tick,
    output logic              playing,
    output logic              done
);

`ifdef BEAT_SEQ_ARTIC_EN
    localparam bit ARTIC_EN = 1'b1;
`else
    localparam bit ARTIC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [NOTE_W-1:0]   left_note_q, left_note_d;
    logic [NOTE_W-1:0]   right_note_q, right_note_d;
    logic                playing_q, playing_d;
    logic                done_q, done_d;

    logic [DIV_W-1:0]    eff_div;
    logic                terminal;
    logic                go;
    logic                gap_mute;

    assign eff_div  = (tempo_div == '0) ? DIV_W'(1) : tempo_div;
    // >= rather than == so a mid-beat tempo reduction ends the beat at once.
    assign terminal = (div_cnt_q >= eff_div - DIV_W'(1));
    assign go       = start && !pause && (song_len != '0);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        div_cnt_d  = div_cnt_q;
        beat_tick  = 1'b0;
        if (stop) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            div_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state_d    = S_PLAY;
                        beat_cnt_d = BEAT_W'(1);
                        div_cnt_d  = '0;
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (terminal) begin
                        div_cnt_d = '0;
                        beat_tick = 1'b1;
                        if (beat_cnt_q < song_len) begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end else if (loop_en) begin
                            beat_cnt_d = BEAT_W'(1);
                        end else begin
                            beat_cnt_d = '0;
                            state_d    = S_DONE;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_d = S_PLAY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Gap is judged on the next divider value so the silence lines up with div_cnt.
    assign gap_mute = ARTIC_EN && (eff_div > DIV_W'(GAP)) &&
                      (div_cnt_d >= eff_div - DIV_W'(GAP));

    always_comb begin
        left_note_d  = '0;
        right_note_d = '0;
        if ((state_q == S_PLAY) && (state_d == S_PLAY) && !gap_mute) begin
            left_note_d  = rom_left_note;
            right_note_d = rom_right_note;
        end
    end

    assign playing_d = (state_d == S_PLAY);
    assign done_d    = (state_d == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            div_cnt_q    <= '0;
            left_note_q  <= '0;
            right_note_q <= '0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            div_cnt_q    <= div_cnt_d;
            left_note_q  <= left_note_d;
            right_note_q <= right_note_d;
            playing_q    <= playing_d;
            done_q       <= done_d;
        end
    end

    assign beat_cnt   = beat_cnt_q;
    assign left_note  = left_note_q;
    assign right_note = right_note_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: per-cycle expectations are queued as stimulus is driven
// and compared mid-cycle against the DUT outputs.
module tb_beat_sequencer;
    localparam int NOTE_W = 4;
    localparam int BEAT_W = 7;
    localparam int DIV_W  = 27;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, pause, stop, loop_en;
    logic [BEAT_W-1:0] song_len;
    logic [DIV_W-1:0]  tempo_div;
    logic [NOTE_W-1:0] rom_left_note, rom_right_note;
    logic [BEAT_W-1:0] beat_cnt;
    logic [NOTE_W-1:0] left_note, right_note;
    logic              beat_tick, playing, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beat_sequencer #(.NOTE_W(NOTE_W), .BEAT_W(BEAT_W), .DIV_W(DIV_W), .GAP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .song_len(song_len), .tempo_div(tempo_div),
        .rom_left_note(rom_left_note), .rom_right_note(rom_right_note),
        .beat_cnt(beat_cnt), .left_note(left_note), .right_note(right_note),
        .beat_tick(beat_tick), .playing(playing), .done(done)
    );

    // Song ROM model: distinct non-zero notes for beats 1..8.
    function automatic int rom_l(input int b);
        return (3 * b + 2) % 16;
    endfunction
    function automatic int rom_r(input int b);
        return (5 * b + 3) % 16;
    endfunction
    function automatic int nl(input int prev);
        return (prev == 0) ? 0 : rom_l(prev);
    endfunction
    function automatic int nr(input int prev);
        return (prev == 0) ? 0 : rom_r(prev);
    endfunction
    function automatic bit artic_on();
`ifdef BEAT_SEQ_ARTIC_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    assign rom_left_note  = NOTE_W'(rom_l(int'(beat_cnt)));
    assign rom_right_note = NOTE_W'(rom_r(int'(beat_cnt)));

    typedef struct {
        string tag;
        int beat, ln, rn, tick, play, dn;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue this cycle's expected outputs, then advance to just after the next edge.
    task automatic exp_step(input string tag, input int beat, input int ln, input int rn,
                            input int tick, input int play, input int dn);
        exp_t e;
        e.tag = tag; e.beat = beat; e.ln = ln; e.rn = rn;
        e.tick = tick; e.play = play; e.dn = dn;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check_eq({cur.tag, ".beat"},  int'(beat_cnt),   cur.beat);
            check_eq({cur.tag, ".left"},  int'(left_note),  cur.ln);
            check_eq({cur.tag, ".right"}, int'(right_note), cur.rn);
            check_eq({cur.tag, ".tick"},  int'(beat_tick),  cur.tick);
            check_eq({cur.tag, ".play"},  int'(playing),    cur.play);
            check_eq({cur.tag, ".done"},  int'(done),       cur.dn);
            $display("[%0t] %s beat=%0d L=%0d R=%0d tick=%0d play=%0d done=%0d",
                     $time, cur.tag, beat_cnt, left_note, right_note, beat_tick, playing, done);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int beat, prev, ln, rn;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        song_len = '0; tempo_div = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_step("reset", 0, 0, 0, 0, 0, 0);

        // Basic play: 4 beats, 3 cycles each, then DONE.
        song_len = 7'd4; tempo_div = 27'd3; loop_en = 1'b0; start = 1'b1;
        exp_step("a_idle", 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            beat = k / 3 + 1;
            prev = (k == 0) ? 0 : (k - 1) / 3 + 1;
            exp_step("a_play", beat, nl(prev), nr(prev), (k % 3 == 2) ? 1 : 0, 1, 0);
        end
        exp_step("a_done", 0, 0, 0, 0, 0, 1);
        exp_step("a_done", 0, 0, 0, 0, 0, 1);

        // Restart from DONE into a looping 3-beat song, then stop.
        song_len = 7'd3; tempo_div = 27'd2; loop_en = 1'b1; start = 1'b1;
        exp_step("b_done", 0, 0, 0, 0, 0, 1);
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            beat = (k / 2) % 3 + 1;
            prev = (k == 0) ? 0 : ((k - 1) / 2) % 3 + 1;
            exp_step("b_loop", beat, nl(prev), nr(prev), (k % 2 == 1) ? 1 : 0, 1, 0);
        end
        stop = 1'b1;
        exp_step("b_stop", 1, nl(3), nr(3), 0, 1, 0);
        stop = 1'b0; loop_en = 1'b0;
        exp_step("b_idle", 0, 0, 0, 0, 0, 0);

        // Pause for 5 cycles at beat 2, div_cnt 1.
        song_len = 7'd4; tempo_div = 27'd3; start = 1'b1;
        exp_step("c_idle", 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat = k / 3 + 1;
            prev = (k == 0) ? 0 : (k - 1) / 3 + 1;
            exp_step("c_play", beat, nl(prev), nr(prev), (k % 3 == 2) ? 1 : 0, 1, 0);
        end
        pause = 1'b1;
        exp_step("c_pause_in", 2, nl(2), nr(2), 0, 1, 0);
        for (int k = 0; k < 4; k++) exp_step("c_paused", 2, 0, 0, 0, 0, 0);
        pause = 1'b0;
        exp_step("c_release", 2, 0, 0, 0, 0, 0);
        exp_step("c_resume", 2, 0, 0, 0, 1, 0);
        exp_step("c_term", 2, nl(2), nr(2), 1, 1, 0);
        exp_step("c_beat3", 3, nl(2), nr(2), 0, 1, 0);
        stop = 1'b1;
        exp_step("c_stop", 3, nl(3), nr(3), 0, 1, 0);
        stop = 1'b0;
        exp_step("c_idle2", 0, 0, 0, 0, 0, 0);

        // song_len 0 ignores start.
        song_len = 7'd0; start = 1'b1;
        for (int k = 0; k < 3; k++) exp_step("d_zero", 0, 0, 0, 0, 0, 0);
        start = 1'b0;

        // tempo_div 0 behaves as 1.
        song_len = 7'd2; tempo_div = 27'd0; start = 1'b1;
        exp_step("e_idle", 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        exp_step("e_b1", 1, 0, 0, 1, 1, 0);
        exp_step("e_b2", 2, nl(1), nr(1), 1, 1, 0);
        exp_step("e_done", 0, 0, 0, 0, 0, 1);
        stop = 1'b1;
        exp_step("e_stop", 0, 0, 0, 0, 0, 1);
        stop = 1'b0;
        exp_step("e_idle2", 0, 0, 0, 0, 0, 0);

        // Tempo 10 -> 2 at div_cnt 7 ends the beat immediately.
        song_len = 7'd3; tempo_div = 27'd10; start = 1'b1;
        exp_step("f_idle", 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ln = (k == 0 || (artic_on() && k == 6)) ? 0 : rom_l(1);
            rn = (k == 0 || (artic_on() && k == 6)) ? 0 : rom_r(1);
            exp_step("f_b1", 1, ln, rn, 0, 1, 0);
        end
        tempo_div = 27'd2;
        exp_step("f_change", 1, artic_on() ? 0 : rom_l(1), artic_on() ? 0 : rom_r(1), 1, 1, 0);
        exp_step("f_b2", 2, rom_l(1), rom_r(1), 0, 1, 0);
        exp_step("f_b2t", 2, rom_l(2), rom_r(2), 1, 1, 0);
        stop = 1'b1;
        exp_step("f_stop", 3, rom_l(2), rom_r(2), 0, 1, 0);
        stop = 1'b0;
        exp_step("f_idle2", 0, 0, 0, 0, 0, 0);

        // Articulation: with the gap enabled notes are silent for div_cnt 6..9.
        song_len = 7'd2; tempo_div = 27'd10; start = 1'b1;
        exp_step("g_idle", 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            beat = k / 10 + 1;
            prev = (k == 0) ? 0 : (k - 1) / 10 + 1;
            ln = nl(prev);
            rn = nr(prev);
            if (artic_on() && (k % 10) >= 6) begin
                ln = 0;
                rn = 0;
            end
            exp_step("g_play", beat, ln, rn, (k % 10 == 9) ? 1 : 0, 1, 0);
        end
        exp_step("g_done", 0, 0, 0, 0, 0, 1);
        stop = 1'b1;
        exp_step("g_stop", 0, 0, 0, 0, 0, 1);
        stop = 1'b0;

        // Asynchronous reset while playing beat 5.
        song_len = 7'd8; tempo_div = 27'd2; start = 1'b1;
        exp_step("h_idle", 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            beat = k / 2 + 1;
            prev = (k == 0) ? 0 : (k - 1) / 2 + 1;
            exp_step("h_play", beat, nl(prev), nr(prev), (k % 2 == 1) ? 1 : 0, 1, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("h_async.beat",  int'(beat_cnt),   0);
        check_eq("h_async.left",  int'(left_note),  0);
        check_eq("h_async.right", int'(right_note), 0);
        check_eq("h_async.tick",  int'(beat_tick),  0);
        check_eq("h_async.play",  int'(playing),    0);
        check_eq("h_async.done",  int'(done),       0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_step("h_after", 0, 0, 0, 0, 0, 0);
        exp_step("h_after", 0, 0, 0, 0, 0, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
